id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline stage of the pipelined core: registers decoded instruction state at the decode/execute boundary and drives the 64-bit ALU directly. It generates the 4-bit `alu_code` from `alu_op`/`funct3`/`funct7[5]` and applies EX/MEM and MEM/WB operand forwarding. It selects the immediate for `rs2` and detects load-use hazards for the hazard controller. It supports stall (hold) and flush (bubble insertion).

## Interface
- `XLEN`, 64: datapath width.
- `RA_W`, 5: register-address width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `stall` in 1: hold all stage registers.
- `flush` in 1: load a bubble.
- `id_valid`, `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`, `id_branch`, `id_alu_src` in 1 each: decode control.
- `id_alu_op` in 2: 00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
- `id_funct3` in 3; `id_funct7_b5` in 1.
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm` in XLEN (imm already sign-extended).
- `id_rs1`, `id_rs2`, `id_rd` in RA_W.
- `exm_reg_write` in 1, `exm_rd` in RA_W, `exm_result` in XLEN: EX/MEM bypass.
- `mwb_reg_write` in 1, `mwb_rd` in RA_W, `mwb_result` in XLEN: MEM/WB bypass.
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`, `ex_branch` out 1: registered control.
- `ex_pc` out XLEN; `ex_rd` out RA_W; `alu_code` out 4 (registered).
- `alu_rs1`, `alu_rs2`, `ex_store_data` out XLEN: forwarded operands (combinational).
- `fwd_a`, `fwd_b` out 2: 00 register file, 10 EX/MEM, 01 MEM/WB.
- `load_use_stall` out 1: hazard request to the controller.

## Operation
- ALU decode, combinational on `id_*`, registered into `alu_code`:
  - `alu_op`=00 -> 0010 ADD; 01 -> 0011 SUB.
  - `alu_op`=10: f3=000 & b5=0 -> 0010; f3=000 & b5=1 -> 0011; f3=111 -> 0000 AND; f3=110 -> 0001 OR; else 1111.
  - `alu_op`=11: f3=000 -> 0010 (b5 ignored); 111 -> 0000; 110 -> 0001; else 1111.
  - 1111 is unsupported; the ALU returns 0.
- Register update each edge, by priority:
  - `flush`: every output register cleared to 0. This is a bubble: valid=0, no writes, data zero.
  - else `stall`: all registers hold.
  - else load `id_*`.
- Forwarding, evaluated independently for A (`ex_rs1` vs `exm_rd`/`mwb_rd`) and B (`ex_rs2`):
  - EX/MEM wins if `exm_reg_write` & `exm_rd`!=0 & match.
  - else MEM/WB if `mwb_reg_write` & `mwb_rd`!=0 & match.
  - else 00.
  - Register x0 is never forwarded.
- `alu_rs1` = forwarded rs1.
- `ex_store_data` = forwarded rs2.
- `alu_rs2` = `ex_alu_src` ? `ex_imm` : forwarded rs2.
- `load_use_stall` = `ex_valid` & `ex_mem_read` & `ex_rd`!=0 & (`ex_rd`==`id_rs1` | `ex_rd`==`id_rs2`).
  - The controller responds by stalling PC and IF/ID and asserting `flush` here the same cycle.
- Arithmetic: no arithmetic here; all data paths pass through at full XLEN.

## Timing
- Decode -> `ex_*`/`alu_code`: 1 cycle.
- Forwarding muxes, `fwd_*` and `load_use_stall`: 0 cycles, combinational on current register state and bypass inputs.
- `rst_n` low: every registered output is 0 immediately (`alu_code`=0000, `ex_valid`=0), including mid-operation. Combinational outputs follow from the zeroed state.
- Reset release: first capture at the next rising edge with `rst_n` high.
- `stall` and `flush` in the same cycle: flush wins.
- A bubble (`ex_valid`=0, `ex_reg_write`=0) cannot create a hazard, and a bubble's rd=0 cannot be forwarded.

## Structure
- Shared package `riscv_pkg` holds:
  - ALU code constants: AND 0000, OR 0001, ADD 0010, SUB 0011, INVALID 1111.
  - `alu_op` encodings.
  - Forward-select encodings.
- Sub-module `alu_ctrl`: combinational decode of `alu_op`/`funct3`/`funct7_b5` into `alu_code`, reusable by the single-cycle core.
- Forwarding and hazard logic stay in this block.

## Test plan
- Reset: load a valid R-type, then drop `rst_n` between edges -> all `ex_*` outputs 0 and `alu_code`=0000 without waiting for a clock edge.
- Decode: `alu_op`=10, f3=000, b5=1, rs1_data=10, rs2_data=3 -> next cycle `alu_code`=0011, `alu_rs1`=10, `alu_rs2`=3. f3=101 -> `alu_code`=1111.
- Forwarding priority: `ex_rs1`=5, `exm_rd`=`mwb_rd`=5, both write -> `fwd_a`=10, `alu_rs1`=`exm_result`. Drop `exm_reg_write` -> `fwd_a`=01. Use rd=0 -> `fwd_a`=00.
- Immediate: `alu_op`=11, `alu_src`=1, imm=0xFFFF_FFFF_FFFF_FFFC -> `alu_code`=0010, `alu_rs2`=0xFFFF_FFFF_FFFF_FFFC, `ex_store_data` = forwarded rs2.
- Stall/flush: `stall`=1 with changing `id_*` -> outputs unchanged over 3 cycles. `stall`=`flush`=1 -> bubble (`ex_valid`=0, `ex_reg_write`=0).
- Load-use: EX holds a load with rd=7, ID presents rs2=7 -> `load_use_stall`=1. Same with rd=0, or with `ex_valid`=0 -> 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the pipelined and single-cycle cores: ALU codes,
// alu_op classes, forward-select values and the EX control bundle.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_OR      = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_SUB     = 4'b0011,
    ALU_INVALID = 4'b1111
  } alu_code_e;

  typedef enum logic [1:0] {
    AOP_MEM    = 2'b00,
    AOP_BRANCH = 2'b01,
    AOP_RTYPE  = 2'b10,
    AOP_ITYPE  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MWB = 2'b01,
    FWD_EXM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
    logic alu_src;
  } ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode/execute boundary bundle: ID-side inputs, bypass inputs, EX-side outputs.
interface id_ex_stage_if #(
  parameter int XLEN = 64,
  parameter int RA_W = 5
);
  logic            stall;
  logic            flush;
  logic            id_valid;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            id_mem_write;
  logic            id_mem_to_reg;
  logic            id_branch;
  logic            id_alu_src;
  logic [1:0]      id_alu_op;
  logic [2:0]      id_funct3;
  logic            id_funct7_b5;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic [RA_W-1:0] id_rd;
  logic            exm_reg_write;
  logic [RA_W-1:0] exm_rd;
  logic [XLEN-1:0] exm_result;
  logic            mwb_reg_write;
  logic [RA_W-1:0] mwb_rd;
  logic [XLEN-1:0] mwb_result;
  logic            ex_valid;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_mem_to_reg;
  logic            ex_branch;
  logic [XLEN-1:0] ex_pc;
  logic [RA_W-1:0] ex_rd;
  logic [3:0]      alu_code;
  logic [XLEN-1:0] alu_rs1;
  logic [XLEN-1:0] alu_rs2;
  logic [XLEN-1:0] ex_store_data;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;
  logic            load_use_stall;

  modport master (
    output stall, flush, id_valid, id_reg_write, id_mem_read, id_mem_write,
           id_mem_to_reg, id_branch, id_alu_src, id_alu_op, id_funct3,
           id_funct7_b5, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1,
           id_rs2, id_rd, exm_reg_write, exm_rd, exm_result, mwb_reg_write,
           mwb_rd, mwb_result,
    input  ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           ex_branch, ex_pc, ex_rd, alu_code, alu_rs1, alu_rs2, ex_store_data,
           fwd_a, fwd_b, load_use_stall
  );

  modport slave (
    input  stall, flush, id_valid, id_reg_write, id_mem_read, id_mem_write,
           id_mem_to_reg, id_branch, id_alu_src, id_alu_op, id_funct3,
           id_funct7_b5, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1,
           id_rs2, id_rd, exm_reg_write, exm_rd, exm_result, mwb_reg_write,
           mwb_rd, mwb_result,
    output ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           ex_branch, ex_pc, ex_rd, alu_code, alu_rs1, alu_rs2, ex_store_data,
           fwd_a, fwd_b, load_use_stall
  );
endinterface

// File: rtl/alu_ctrl.sv
// Combinational ALU-control decode; shared with the single-cycle core.
module alu_ctrl
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output logic [3:0] alu_code
);

  always_comb begin
    alu_code = ALU_INVALID;
    case (alu_op)
      AOP_MEM:    alu_code = ALU_ADD;
      AOP_BRANCH: alu_code = ALU_SUB;
      AOP_RTYPE: begin
        case (funct3)
          3'b000:  alu_code = funct7_b5 ? ALU_SUB : ALU_ADD;
          3'b111:  alu_code = ALU_AND;
          3'b110:  alu_code = ALU_OR;
          default: alu_code = ALU_INVALID;
        endcase
      end
      AOP_ITYPE: begin
        // funct7[5] is immediate payload for ADDI, so it cannot select SUB
        case (funct3)
          3'b000:  alu_code = ALU_ADD;
          3'b111:  alu_code = ALU_AND;
          3'b110:  alu_code = ALU_OR;
          default: alu_code = ALU_INVALID;
        endcase
      end
      default: alu_code = ALU_INVALID;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU decode, EX/MEM + MEM/WB operand bypass
// and load-use hazard detection.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int RA_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
);

  ex_ctrl_t        id_ctrl, ex_ctrl;
  logic [3:0]      id_code, code_q;
  logic [XLEN-1:0] pc_q, rs1d_q, rs2d_q, imm_q;
  logic [RA_W-1:0] rs1_q, rs2_q, rd_q;
  logic [1:0]      fwd_a, fwd_b;
  logic [XLEN-1:0] opnd_a, opnd_b;

  assign id_ctrl = '{valid:      bus.id_valid,
                     reg_write:  bus.id_reg_write,
                     mem_read:   bus.id_mem_read,
                     mem_write:  bus.id_mem_write,
                     mem_to_reg: bus.id_mem_to_reg,
                     branch:     bus.id_branch,
                     alu_src:    bus.id_alu_src};

  alu_ctrl u_alu_ctrl (
    .alu_op    (bus.id_alu_op),
    .funct3    (bus.id_funct3),
    .funct7_b5 (bus.id_funct7_b5),
    .alu_code  (id_code)
  );

  // Flush zeroes everything so a bubble carries rd=0 and can never bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl <= '0;
      code_q  <= '0;
      pc_q    <= '0;
      rs1d_q  <= '0;
      rs2d_q  <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
    end else if (bus.flush) begin
      ex_ctrl <= '0;
      code_q  <= '0;
      pc_q    <= '0;
      rs1d_q  <= '0;
      rs2d_q  <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
    end else if (!bus.stall) begin
      ex_ctrl <= id_ctrl;
      code_q  <= id_code;
      pc_q    <= bus.id_pc;
      rs1d_q  <= bus.id_rs1_data;
      rs2d_q  <= bus.id_rs2_data;
      imm_q   <= bus.id_imm;
      rs1_q   <= bus.id_rs1;
      rs2_q   <= bus.id_rs2;
      rd_q    <= bus.id_rd;
    end
  end

  // Youngest producer (EX/MEM) wins; x0 is hardwired zero and never bypassed.
  always_comb begin
    fwd_a = FWD_RF;
    if (bus.exm_reg_write && bus.exm_rd != '0 && bus.exm_rd == rs1_q)
      fwd_a = FWD_EXM;
    else if (bus.mwb_reg_write && bus.mwb_rd != '0 && bus.mwb_rd == rs1_q)
      fwd_a = FWD_MWB;

    fwd_b = FWD_RF;
    if (bus.exm_reg_write && bus.exm_rd != '0 && bus.exm_rd == rs2_q)
      fwd_b = FWD_EXM;
    else if (bus.mwb_reg_write && bus.mwb_rd != '0 && bus.mwb_rd == rs2_q)
      fwd_b = FWD_MWB;
  end

  always_comb begin
    case (fwd_a)
      FWD_EXM: opnd_a = bus.exm_result;
      FWD_MWB: opnd_a = bus.mwb_result;
      default: opnd_a = rs1d_q;
    endcase
    case (fwd_b)
      FWD_EXM: opnd_b = bus.exm_result;
      FWD_MWB: opnd_b = bus.mwb_result;
      default: opnd_b = rs2d_q;
    endcase
  end

  assign bus.ex_valid      = ex_ctrl.valid;
  assign bus.ex_reg_write  = ex_ctrl.reg_write;
  assign bus.ex_mem_read   = ex_ctrl.mem_read;
  assign bus.ex_mem_write  = ex_ctrl.mem_write;
  assign bus.ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign bus.ex_branch     = ex_ctrl.branch;
  assign bus.ex_pc         = pc_q;
  assign bus.ex_rd         = rd_q;
  assign bus.alu_code      = code_q;
  assign bus.fwd_a         = fwd_a;
  assign bus.fwd_b         = fwd_b;
  assign bus.alu_rs1       = opnd_a;
  assign bus.ex_store_data = opnd_b;
  assign bus.alu_rs2       = ex_ctrl.alu_src ? imm_q : opnd_b;

  assign bus.load_use_stall = ex_ctrl.valid && ex_ctrl.mem_read && rd_q != '0 &&
                              (rd_q == bus.id_rs1 || rd_q == bus.id_rs2);

endmodule
